// File: rtl/huffman_mcu_scheduler.sv
// huffman_mcu_scheduler: feeds Y/Cb/Cr zig-zag blocks in MCU order to the shared Huffman controller with DC prediction
module huffman_mcu_scheduler #(
   parameter int Y_PER_MCU = 1,
   parameter int PIX_W     = 10
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_frame_start,
   input  logic [15:0]           i_num_mcu,
   input  logic                  i_y_valid,
   output logic                  o_y_ready,
   input  logic [64*PIX_W-1:0]   i_y_block,
   input  logic                  i_cb_valid,
   output logic                  o_cb_ready,
   input  logic [64*PIX_W-1:0]   i_cb_block,
   input  logic                  i_cr_valid,
   output logic                  o_cr_ready,
   input  logic [64*PIX_W-1:0]   i_cr_block,
   output logic                  o_huff_start,
   output logic                  o_huff_is_luminance,
   output logic [64*PIX_W-1:0]   o_huff_zigzag,
   input  logic                  i_huff_active,
   output logic                  o_busy,
   output logic [1:0]            o_comp_id,
   output logic                  o_block_done,
   output logic                  o_mcu_done,
   output logic                  o_frame_done,
   output logic [15:0]           o_mcu_count
);
   localparam int BW = 64 * PIX_W;
   typedef enum logic [2:0] {S_IDLE, S_WAIT_BLK, S_LOAD, S_START, S_WAIT_ACT, S_WAIT_DONE, S_NEXT} state_t;
   state_t             r_state;
   logic [2:0]         r_seq;
   logic [15:0]        r_num_mcu;
   logic [15:0]        r_mcu_count;
   logic [PIX_W-1:0]   r_pred_y;
   logic [PIX_W-1:0]   r_pred_cb;
   logic [PIX_W-1:0]   r_pred_cr;
   logic               r_y_ready;
   logic               r_cb_ready;
   logic               r_cr_ready;
   logic               r_huff_start;
   logic               r_is_lum;
   logic [BW-1:0]      r_zigzag;
   logic               r_busy;
   logic [1:0]         r_comp_id;
   logic               r_block_done;
   logic               r_mcu_done;
   logic               r_frame_done;
   logic [1:0]         w_exp;
   logic               w_acc;
   logic [BW-1:0]      w_blk;
   logic [PIX_W-1:0]   w_pred;
   logic [PIX_W-1:0]   w_dc;
   logic [PIX_W:0]     w_diff;
   logic [PIX_W-1:0]   w_dc_sat;

   assign o_y_ready           = r_y_ready;
   assign o_cb_ready          = r_cb_ready;
   assign o_cr_ready          = r_cr_ready;
   assign o_huff_start        = r_huff_start;
   assign o_huff_is_luminance = r_is_lum;
   assign o_huff_zigzag       = r_zigzag;
   assign o_busy              = r_busy;
   assign o_comp_id           = r_comp_id;
   assign o_block_done        = r_block_done;
   assign o_mcu_done          = r_mcu_done;
   assign o_frame_done        = r_frame_done;
   assign o_mcu_count         = r_mcu_count;

   // expected component, acceptance and saturated DC difference of the block on offer
   always_comb begin
      w_exp    = (r_seq < 3'(Y_PER_MCU)) ? 2'd0 : (r_seq == 3'(Y_PER_MCU)) ? 2'd1 : 2'd2;
      w_acc    = (r_y_ready & i_y_valid) | (r_cb_ready & i_cb_valid) | (r_cr_ready & i_cr_valid);
      w_blk    = (w_exp == 2'd0) ? i_y_block : (w_exp == 2'd1) ? i_cb_block : i_cr_block;
      w_pred   = (w_exp == 2'd0) ? r_pred_y : (w_exp == 2'd1) ? r_pred_cb : r_pred_cr;
      w_dc     = w_blk[PIX_W-1:0];
      w_diff   = {w_dc[PIX_W-1], w_dc} - {w_pred[PIX_W-1], w_pred};
      w_dc_sat = (w_diff[PIX_W] == w_diff[PIX_W-1]) ? w_diff[PIX_W-1:0]
               : {w_diff[PIX_W], {(PIX_W-1){~w_diff[PIX_W]}}};
   end

   // block sequencing FSM; every output is a register so the encoder sees stable values
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_seq        <= 3'd0;
         r_num_mcu    <= 16'd0;
         r_mcu_count  <= 16'd0;
         r_pred_y     <= '0;
         r_pred_cb    <= '0;
         r_pred_cr    <= '0;
         r_y_ready    <= 1'b0;
         r_cb_ready   <= 1'b0;
         r_cr_ready   <= 1'b0;
         r_huff_start <= 1'b0;
         r_is_lum     <= 1'b0;
         r_zigzag     <= '0;
         r_busy       <= 1'b0;
         r_comp_id    <= 2'd0;
         r_block_done <= 1'b0;
         r_mcu_done   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_huff_start <= 1'b0;
         r_block_done <= 1'b0;
         r_mcu_done   <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: if (i_frame_start) begin
               r_num_mcu   <= (i_num_mcu == 16'd0) ? 16'd1 : i_num_mcu;
               r_pred_y    <= '0;
               r_pred_cb   <= '0;
               r_pred_cr   <= '0;
               r_mcu_count <= 16'd0;
               r_seq       <= 3'd0;
               r_busy      <= 1'b1;
               r_y_ready   <= 1'b1;
               r_state     <= S_WAIT_BLK;
            end
            S_WAIT_BLK: if (w_acc) begin
               r_y_ready  <= 1'b0;
               r_cb_ready <= 1'b0;
               r_cr_ready <= 1'b0;
               r_zigzag   <= {w_blk[BW-1:PIX_W], w_dc_sat};
               if (w_exp == 2'd0) r_pred_y <= w_dc;
               if (w_exp == 2'd1) r_pred_cb <= w_dc;
               if (w_exp == 2'd2) r_pred_cr <= w_dc;
               r_is_lum   <= (w_exp == 2'd0);
               r_comp_id  <= w_exp;
               r_state    <= S_LOAD;
            end
            S_LOAD: begin
               r_huff_start <= 1'b1;
               r_state      <= S_START;
            end
            S_START: r_state <= S_WAIT_ACT;
            S_WAIT_ACT: if (i_huff_active) r_state <= S_WAIT_DONE;
            S_WAIT_DONE: if (!i_huff_active) begin
               r_block_done <= 1'b1;
               r_state      <= S_NEXT;
               if (r_comp_id == 2'd2) begin
                  r_seq        <= 3'd0;
                  r_mcu_done   <= 1'b1;
                  r_mcu_count  <= r_mcu_count + 16'd1;
                  r_frame_done <= (r_mcu_count + 16'd1 == r_num_mcu);
               end else begin
                  r_seq <= r_seq + 3'd1;
               end
            end
            S_NEXT: if (r_frame_done) begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end else begin
               r_y_ready  <= (w_exp == 2'd0);
               r_cb_ready <= (w_exp == 2'd1);
               r_cr_ready <= (w_exp == 2'd2);
               r_state    <= S_WAIT_BLK;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_huffman_mcu_scheduler.sv
// tb_huffman_mcu_scheduler: directed frames checked against a spec-level DC prediction model
module tb_huffman_mcu_scheduler;
   localparam int YPM = 1;
   localparam int PW  = 10;
   localparam int BW  = 64 * PW;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic fs = 1'b0;
   logic [15:0] num = 16'd0;
   logic yv = 1'b0, cbv = 1'b0, crv = 1'b0;
   logic [BW-1:0] yb = '0, cbb = '0, crb = '0;
   logic yr, cbr, crr;
   logic hstart, hlum, hact = 1'b0;
   logic [BW-1:0] hzz;
   logic busy, bdone, mdone, fdone;
   logic [1:0] cid;
   logic [15:0] mcnt;
   int n_vec = 0;
   int n_err = 0;
   logic [BW-1:0] yq[$], cbq[$], crq[$];
   logic [BW-1:0] eqy[$], eqcb[$], eqcr[$];
   int dc_log[$];
   int lum_log[$];
   int m_pred[3];
   int m_idx = 0, m_mcu = 0, m_num = 0, n_mdone = 0, n_fdone = 0;
   int act_len = 5;
   bit m_busy = 0, m_end = 0, in_flight = 0, chk_on = 0;
   logic [BW-1:0] cur;
   logic cur_lum;
   logic [1:0] cur_cid;

   huffman_mcu_scheduler #(.Y_PER_MCU(YPM), .PIX_W(PW)) dut (
      .i_clock(clk), .i_reset(rst), .i_frame_start(fs), .i_num_mcu(num),
      .i_y_valid(yv), .o_y_ready(yr), .i_y_block(yb),
      .i_cb_valid(cbv), .o_cb_ready(cbr), .i_cb_block(cbb),
      .i_cr_valid(crv), .o_cr_ready(crr), .i_cr_block(crb),
      .o_huff_start(hstart), .o_huff_is_luminance(hlum), .o_huff_zigzag(hzz),
      .i_huff_active(hact), .o_busy(busy), .o_comp_id(cid),
      .o_block_done(bdone), .o_mcu_done(mdone), .o_frame_done(fdone), .o_mcu_count(mcnt));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int comp_of(input int i);
      int s;
      s = i % (YPM + 2);
      return (s < YPM) ? 0 : (s == YPM) ? 1 : 2;
   endfunction

   function automatic logic [BW-1:0] mk_blk(input int dc);
      logic [BW-1:0] b;
      for (int i = 1; i < 64; i++) b[i*PW +: PW] = PW'($urandom);
      b[PW-1:0] = PW'(dc);
      return b;
   endfunction

   task automatic push(input int c, input int dc);
      logic [BW-1:0] b;
      b = mk_blk(dc);
      if (c == 0) begin yq.push_back(b); eqy.push_back(b); end
      else if (c == 1) begin cbq.push_back(b); eqcb.push_back(b); end
      else begin crq.push_back(b); eqcr.push_back(b); end
   endtask

   task automatic frame(input int n);
      @(posedge clk); #1 fs = 1'b1; num = 16'(n);
      @(posedge clk); #1 fs = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      repeat (3) @(posedge clk);
      while (busy && k < budget) begin @(posedge clk); k++; end
      if (k >= budget) begin
         n_vec++; n_err++;
         $display("FAIL frame_timeout: busy still 1 after %0d cycles", budget);
      end
      #1;
   endtask

   // block sources: each component offers the head of its queue until accepted
   initial forever begin
      bit hy, hb, hr;
      @(posedge clk);
      hy = yv && yr; hb = cbv && cbr; hr = crv && crr;
      #1;
      if (hy) void'(yq.pop_front());
      if (hb) void'(cbq.pop_front());
      if (hr) void'(crq.pop_front());
      yv = yq.size() > 0;   if (yv) yb = yq[0];
      cbv = cbq.size() > 0; if (cbv) cbb = cbq[0];
      crv = crq.size() > 0; if (crv) crb = crq[0];
   end

   // encoder stand-in: busy for act_len cycles after each start pulse
   initial forever begin
      @(posedge clk); #1;
      if (hstart) begin
         @(posedge clk); #1 hact = 1'b1;
         repeat (act_len) @(posedge clk);
         #1 hact = 1'b0;
      end
   end

   // frame-level model state: busy, counters and predictors follow frame_start/reset/frame end
   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0; m_end = 0; m_mcu = 0; m_idx = 0; in_flight = 0;
         for (int i = 0; i < 3; i++) m_pred[i] = 0;
      end else if (m_end) begin
         m_busy = 0; m_end = 0;
      end else if (fs && !m_busy) begin
         m_busy = 1; m_num = (num == 16'd0) ? 1 : int'(num); m_mcu = 0; m_idx = 0;
         for (int i = 0; i < 3; i++) m_pred[i] = 0;
      end
   end

   // per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (!rst && chk_on) begin
         int nr, c, dc, d, ac;
         logic [BW-1:0] b;
         nr = int'(yr) + int'(cbr) + int'(crr);
         chk("busy", BW'(busy), BW'(m_busy));
         if (!m_busy || in_flight) chk("ready_idle", BW'(nr), '0);
         else if (nr > 0) begin
            ac = yr ? 0 : cbr ? 1 : 2;
            chk("ready_count", BW'(nr), BW'(1));
            chk("ready_comp", BW'(ac), BW'(comp_of(m_idx)));
         end
         if (hstart) begin
            chk("start_in_flight", BW'(in_flight), '0);
            c = comp_of(m_idx);
            if (c == 0 && eqy.size() > 0) b = eqy.pop_front();
            else if (c == 1 && eqcb.size() > 0) b = eqcb.pop_front();
            else if (c == 2 && eqcr.size() > 0) b = eqcr.pop_front();
            else begin b = '0; n_vec++; n_err++; $display("FAIL start_no_block: comp %0d had no block", c); end
            dc = int'($signed(b[PW-1:0]));
            d = dc - m_pred[c];
            d = (d > 511) ? 511 : (d < -512) ? -512 : d;
            m_pred[c] = dc;
            cur = b; cur[PW-1:0] = PW'(d);
            cur_lum = (c == 0); cur_cid = 2'(c);
            chk("zigzag", hzz, cur);
            chk("is_lum", BW'(hlum), BW'(cur_lum));
            chk("comp_id", BW'(cid), BW'(cur_cid));
            dc_log.push_back(int'($signed(hzz[PW-1:0])));
            lum_log.push_back(int'(hlum));
            in_flight = 1;
         end else if (in_flight && !bdone) begin
            chk("zigzag_stable", hzz, cur);
            chk("lum_stable", BW'({hlum, cid}), BW'({cur_lum, cur_cid}));
         end
         if (bdone) begin
            chk("done_in_flight", BW'(in_flight), BW'(1));
            chk("done_after_active", BW'(hact), '0);
            c = comp_of(m_idx);
            m_idx++;
            in_flight = 0;
            if (c == 2) begin
               m_mcu++;
               chk("mcu_done", BW'(mdone), BW'(1));
               chk("frame_done", BW'(fdone), BW'(m_mcu == m_num));
               if (m_mcu == m_num) m_end = 1;
            end else chk("no_mcu_done", BW'({mdone, fdone}), '0);
            n_mdone += int'(mdone);
            n_fdone += int'(fdone);
         end else chk("no_pulses", BW'({mdone, fdone}), '0);
         chk("mcu_count", BW'(mcnt), BW'(m_mcu));
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_zz"}, hzz, '0);
      chk({tag, "_flags"}, BW'({yr, cbr, crr, hstart, hlum, busy, bdone, mdone, fdone}), '0);
      chk({tag, "_cid_cnt"}, BW'({cid, mcnt}), '0);
   endtask

   task automatic clear_logs();
      dc_log.delete(); lum_log.delete(); n_mdone = 0; n_fdone = 0;
   endtask

   initial begin
      int k;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");
      chk_on = 1;
      // 1: single 4:4:4 MCU
      clear_logs();
      push(0, 100); push(1, -20); push(2, 5);
      frame(1);
      wait_idle(200);
      chk("t1_nblk", BW'(dc_log.size()), BW'(3));
      if (dc_log.size() == 3) begin
         chk("t1_dc0", BW'(dc_log[0]), BW'(100));
         chk("t1_dc1", BW'(dc_log[1]), BW'(-20));
         chk("t1_dc2", BW'(dc_log[2]), BW'(5));
         chk("t1_lum", BW'({lum_log[0][0], lum_log[1][0], lum_log[2][0]}), BW'(3'b100));
      end
      chk("t1_counts", BW'({n_mdone[3:0], n_fdone[3:0]}), BW'(8'h11));
      chk("t1_end", BW'({busy, mcnt}), BW'(17'd1));
      // 2: two MCUs, differences against previous MCU; mid-frame frame_start ignored
      clear_logs();
      push(0, 100); push(1, -20); push(2, 5); push(0, 130); push(1, -25); push(2, 7);
      frame(2);
      repeat (4) @(posedge clk);
      #1 fs = 1'b1; num = 16'd9;
      @(posedge clk); #1 fs = 1'b0;
      wait_idle(400);
      chk("t2_nblk", BW'(dc_log.size()), BW'(6));
      if (dc_log.size() == 6) begin
         chk("t2_y1", BW'(dc_log[3]), BW'(30));
         chk("t2_cb1", BW'(dc_log[4]), BW'(-5));
         chk("t2_cr1", BW'(dc_log[5]), BW'(2));
      end
      chk("t2_end", BW'({busy, mcnt}), BW'(17'd2));
      // 3: saturation in both directions
      clear_logs();
      push(0, -512); push(1, 511); push(2, 0); push(0, 511); push(1, -512); push(2, 0);
      frame(2);
      wait_idle(400);
      if (dc_log.size() == 6) begin
         chk("t3_y0", BW'(dc_log[0]), BW'(-512));
         chk("t3_ysat", BW'(dc_log[3]), BW'(511));
         chk("t3_cbsat", BW'(dc_log[4]), BW'(-512));
      end else chk("t3_nblk", BW'(dc_log.size()), BW'(6));
      // 4: Cr/Cb offered before Y; num_mcu=0 behaves as one MCU
      clear_logs();
      frame(0);
      push(2, 9); push(1, 8);
      repeat (5) @(posedge clk);
      #1 chk("t4_ready", BW'({yr, cbr, crr}), BW'(3'b100));
      push(0, 7);
      wait_idle(200);
      chk("t4_nblk", BW'(dc_log.size()), BW'(3));
      if (dc_log.size() == 3) chk("t4_order", BW'({lum_log[0][0], 8'(dc_log[1]), 8'(dc_log[2])}), BW'({1'b1, 8'd8, 8'd9}));
      chk("t4_end", BW'({busy, mcnt}), BW'(17'd1));
      // 5: long encoder activity keeps block stable and readies low
      clear_logs();
      act_len = 200;
      push(0, 3); push(1, 4); push(2, 5);
      frame(1);
      wait_idle(2000);
      chk("t5_counts", BW'({n_mdone[3:0], n_fdone[3:0]}), BW'(8'h11));
      act_len = 5;
      // 6: reset while the encoder is busy, then a fresh frame predicts from zero
      clear_logs();
      act_len = 30;
      push(0, 77); push(1, 1); push(2, 2);
      frame(1);
      k = 0;
      while (!hact && k < 50) begin @(posedge clk); k++; end
      if (k >= 50) begin n_vec++; n_err++; $display("FAIL t6_active_timeout: no huff_active"); end
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("t6_reset");
      yq.delete(); cbq.delete(); crq.delete(); eqy.delete(); eqcb.delete(); eqcr.delete();
      k = 0;
      while (hact && k < 100) begin @(posedge clk); k++; end
      #1 act_len = 5;
      clear_logs();
      push(0, 50); push(1, -3); push(2, 4);
      frame(1);
      wait_idle(200);
      if (dc_log.size() == 3) chk("t6_dc0", BW'(dc_log[0]), BW'(50));
      else chk("t6_nblk", BW'(dc_log.size()), BW'(3));
      chk("t6_end", BW'({busy, mcnt}), BW'(17'd1));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/huffman_mcu_scheduler.md
Name: huffman_mcu_scheduler

Overview:
Sequences 8x8 zig-zag blocks from the Y, Cb and Cr block buffers into the single shared Huffman encoder controller. It runs in fixed MCU order (Y x Y_PER_MCU, then Cb, then Cr) and performs the per-component DC differential prediction. It drives the controller's start, luminance-select and block-data inputs, and holds them stable until the controller finishes the block. It also counts MCUs and signals frame completion.

Parameters:
Y_PER_MCU, 1, luma blocks per MCU (legal 1..4; 1 = 4:4:4, 2 = 4:2:2, 4 = 4:2:0)
PIX_W, 10, signed bits per coefficient; block bus = 64*PIX_W, element 0 in bits [PIX_W-1:0]

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
frame_start  in  1  pulse; clears predictors and counters, starts frame (honoured only in IDLE)
num_mcu  in  16  MCUs in frame, sampled on frame_start; 0 treated as 1
y_valid / y_ready  in / out  1 / 1  luma block handshake
y_block  in  640  luma zig-zag block
cb_valid / cb_ready  in / out  1 / 1  Cb block handshake
cb_block  in  640  Cb zig-zag block
cr_valid / cr_ready  in / out  1 / 1  Cr block handshake
cr_block  in  640  Cr zig-zag block
huff_start  out  1  one-cycle start pulse to the Huffman controller
huff_is_luminance  out  1  1 for Y blocks, 0 for Cb/Cr
huff_zigzag  out  640  block to the encoder; element 0 replaced by the DC difference
huff_active  in  1  encoder busy flag from the Huffman controller
busy  out  1  frame in progress
comp_id  out  2  component being encoded: 0 = Y, 1 = Cb, 2 = Cr
block_done  out  1  one-cycle pulse at the end of each block
mcu_done  out  1  one-cycle pulse when the Cr block of an MCU ends
frame_done  out  1  one-cycle pulse with the last mcu_done
mcu_count  out  16  MCUs completed in the current frame

Behaviour:
- Reset: all outputs 0; state IDLE; predictors pred_y, pred_cb and pred_cr = 0; sequence index seq = 0. Reset mid-frame abandons the block in flight.
- State IDLE: on frame_start, latch num_mcu, clear predictors, mcu_count and seq, set busy=1, go to WAIT_BLK.
- State WAIT_BLK: assert only the ready of the expected component.
  - seq < Y_PER_MCU expects Y; seq == Y_PER_MCU expects Cb; seq == Y_PER_MCU+1 expects Cr.
  - valid on any other component is ignored and does not block.
  - On the expected valid&&ready, go to LOAD in the same cycle.
- State LOAD (acceptance edge):
  - Latch the block into huff_zigzag.
  - Compute diff = dc - pred[comp] at PIX_W+1 bits.
  - Saturate diff to [-2^(PIX_W-1), 2^(PIX_W-1)-1] (-512..511) and write it to element 0. Elements 1..63 pass unchanged.
  - Set pred[comp] = unsaturated dc.
  - Set huff_is_luminance and comp_id. Go to START.
- State START: huff_start=1 for exactly one cycle; go to WAIT_ACT.
- State WAIT_ACT: wait for huff_active=1, then go to WAIT_DONE. No timeout.
- State WAIT_DONE: on huff_active=0, go to NEXT.
- Stability: huff_zigzag, huff_is_luminance and comp_id are held constant from LOAD through WAIT_DONE, because the encoder re-reads the block for every AC symbol.
- State NEXT: pulse block_done and advance seq.
  - If the finished block was Cr: seq=0, pulse mcu_done, increment mcu_count.
  - If mcu_count+1 == latched num_mcu: also pulse frame_done, clear busy, go to IDLE. mcu_count holds its final value until the next frame_start.
  - Otherwise go to WAIT_BLK.
- Latency: 1 cycle from acceptance to LOAD; huff_start on the following cycle. Block-to-block overhead is 3 cycles plus the encoder time.
- Simultaneous events: frame_start outside IDLE is ignored. Multiple valids in one cycle are resolved by sequence order only. Predictors persist across MCUs and are cleared only by frame_start or reset.
- Ready outputs are 0 in every state except WAIT_BLK.

Test Plan:
1. Y_PER_MCU=1, num_mcu=1; Y/Cb/Cr DC = 100/-20/5 -> huff_zigzag element 0 = 100, -20, 5 in turn; huff_is_luminance = 1,0,0; one mcu_done, frame_done, mcu_count=1, busy=0.
2. num_mcu=2, Y DC 100 then 130 -> second Y block element 0 = 30; Cb/Cr differences computed against the first MCU's values.
3. Saturation: pred_y=-512, next Y DC=511 -> element 0 = 511 (raw difference 1023 clipped); pred_y becomes 511.
4. Ordering: cr_valid and cb_valid high before y_valid -> only y_ready asserts first; Cb accepted next, then Cr; blocks encoded in Y, Cb, Cr order.
5. Stability: huff_active held high for 200 cycles -> huff_zigzag unchanged, no ready asserted, block_done only after huff_active falls.
6. Reset asserted in WAIT_DONE, then frame_start -> all outputs 0 after reset; new frame's first Y difference uses predictor 0.
